// File: rtl/trigger_sync_hub_if.sv
// Control/status bundle between trigger_sync_hub, the host and the trigger array.
// slave: hub side. master: host and trigger-array side.
interface trigger_sync_hub_if #(
  parameter int unsigned NUM_ACTORS = 4,
  parameter int unsigned ROUND_W    = 16
);
  logic                  ap_start;
  logic                  ap_done;
  logic                  ap_ready;
  logic                  ap_idle;
  logic [NUM_ACTORS-1:0] trigger_start;
  logic [NUM_ACTORS-1:0] trigger_idle;
  logic [NUM_ACTORS-1:0] sleep;
  logic [NUM_ACTORS-1:0] sync_exec;
  logic [NUM_ACTORS-1:0] sync_wait;
  logic                  all_sleep;
  logic                  all_sync;
  logic                  all_sync_wait;
  logic [ROUND_W-1:0]    sync_rounds;

  modport slave (
    input  ap_start, trigger_idle, sleep, sync_exec, sync_wait,
    output ap_done, ap_ready, ap_idle, trigger_start,
           all_sleep, all_sync, all_sync_wait, sync_rounds
  );

  modport master (
    output ap_start, trigger_idle, sleep, sync_exec, sync_wait,
    input  ap_done, ap_ready, ap_idle, trigger_start,
           all_sleep, all_sync, all_sync_wait, sync_rounds
  );
endinterface

// File: rtl/trigger_sync_hub.sv
// trigger_sync_hub: starts all triggers of a network together, turns their
// per-actor status vectors into registered network-wide barrier pulses and
// runs the network ap_start/ap_done handshake.
// Optional build macro TRIGGER_SYNC_HUB_ROUND_COUNT_EN adds the saturating
// sync-round counter; without it sync_rounds is tied to zero.
module trigger_sync_hub #(
  parameter int unsigned NUM_ACTORS = 4,
  parameter int unsigned ROUND_W    = 16
) (
  input  logic                ap_clk,
  input  logic                ap_rst,
  trigger_sync_hub_if.slave   hub
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [NUM_ACTORS-1:0] trigger_start_q, trigger_start_d;
  logic                  all_sleep_q, all_sleep_d;
  logic                  all_sync_q, all_sync_d;
  logic                  all_sync_wait_q, all_sync_wait_d;
  logic                  start_accept;
  logic                  cooldown;
  logic                  eval;
  logic                  cond_s, cond_y, cond_w;

  // State register
  always_ff @(posedge ap_clk) begin
    if (ap_rst) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: leave RUN once the final all_sync_wait pulse is on the outputs
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (hub.ap_start)     state_d = S_RUN;
      S_RUN:   if (all_sync_wait_q)  state_d = S_DRAIN;
      S_DRAIN: if (&hub.trigger_idle) state_d = S_DONE;
      S_DONE:                        state_d = S_IDLE;
      default:                       state_d = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register only
  always_comb begin
    hub.ap_idle  = (state_q == S_IDLE);
    hub.ap_done  = (state_q == S_DONE);
    hub.ap_ready = (state_q == S_DONE);
  end

  // Barrier evaluation; a cycle with any pulse high is a cooldown cycle whose
  // status inputs are stale, so every barrier drops in the following cycle.
  // Y wins over S if an illegal network reports both.
  always_comb begin
    start_accept    = (state_q == S_IDLE) && hub.ap_start;
    cooldown        = all_sleep_q | all_sync_q | all_sync_wait_q;
    eval            = (state_q == S_RUN) && !cooldown;
    cond_s          = &hub.sleep;
    cond_y          = &(hub.sync_exec | hub.sync_wait);
    cond_w          = &hub.sync_wait;
    trigger_start_d = {NUM_ACTORS{start_accept}};
    all_sync_d      = eval && cond_y;
    all_sync_wait_d = eval && cond_y && cond_w;
    all_sleep_d     = eval && cond_s && !cond_y;
  end

  // Registered pulse outputs
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      trigger_start_q <= '0;
      all_sleep_q     <= 1'b0;
      all_sync_q      <= 1'b0;
      all_sync_wait_q <= 1'b0;
    end else begin
      trigger_start_q <= trigger_start_d;
      all_sleep_q     <= all_sleep_d;
      all_sync_q      <= all_sync_d;
      all_sync_wait_q <= all_sync_wait_d;
    end
  end

  assign hub.trigger_start = trigger_start_q;
  assign hub.all_sleep     = all_sleep_q;
  assign hub.all_sync      = all_sync_q;
  assign hub.all_sync_wait = all_sync_wait_q;

`ifdef TRIGGER_SYNC_HUB_ROUND_COUNT_EN
  logic [ROUND_W-1:0] sync_rounds_q, sync_rounds_d;

  // Round counter: cleared on accepted start, bumps alongside each all_sync pulse, saturates
  always_comb begin
    sync_rounds_d = sync_rounds_q;
    if (start_accept)
      sync_rounds_d = '0;
    else if (all_sync_d && (sync_rounds_q != '1))
      sync_rounds_d = sync_rounds_q + ROUND_W'(1);
  end

  // Round counter register
  always_ff @(posedge ap_clk) begin
    if (ap_rst) sync_rounds_q <= '0;
    else        sync_rounds_q <= sync_rounds_d;
  end

  assign hub.sync_rounds = sync_rounds_q;
`else
  assign hub.sync_rounds = ROUND_W'(0);
`endif

endmodule

// File: tb/tb_trigger_sync_hub.sv
// Directed, table-driven bench for trigger_sync_hub (NUM_ACTORS=4, ROUND_W=2).
// Each table row: inputs held for one clock, outputs checked #1 after that edge.
module tb_trigger_sync_hub;

  localparam int unsigned NA = 4;
  localparam int unsigned RW = 2;
  localparam int NV = 37;

  logic clk;
  logic rst;

  trigger_sync_hub_if #(.NUM_ACTORS(NA), .ROUND_W(RW)) bus ();

  trigger_sync_hub #(.NUM_ACTORS(NA), .ROUND_W(RW)) dut (
    .ap_clk (clk),
    .ap_rst (rst),
    .hub    (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       rst;
    logic       start;
    logic [3:0] tidle;
    logic [3:0] slp;
    logic [3:0] sx;
    logic [3:0] sw;
    logic       done;
    logic       idle;
    logic [3:0] tstart;
    logic       asl;
    logic       asy;
    logic       asw;
    logic [1:0] rnd;
  } vec_t;

  vec_t vt [NV];
  int   n_vec;
  int   n_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] exp_rounds(input logic [1:0] r);
`ifdef TRIGGER_SYNC_HUB_ROUND_COUNT_EN
    return r;
`else
    return (r & 2'b00);
`endif
  endfunction

  task automatic drive(input logic r, input logic st, input logic [3:0] ti,
                       input logic [3:0] sl, input logic [3:0] sx, input logic [3:0] sw);
    rst            = r;
    bus.ap_start   = st;
    bus.trigger_idle = ti;
    bus.sleep      = sl;
    bus.sync_exec  = sx;
    bus.sync_wait  = sw;
  endtask

  int k;

  initial begin
    n_vec = 0;
    n_err = 0;
    //            rst st  tidle  slp    sx     sw     done idle tstart asl asy asw rnd
    vt[0]  = '{1'b1,1'b0,4'h0,4'h0,4'h0,4'h0, 1'b0,1'b1,4'h0,1'b0,1'b0,1'b0,2'd0}; // reset
    vt[1]  = '{1'b0,1'b0,4'h0,4'h0,4'h0,4'h0, 1'b0,1'b1,4'h0,1'b0,1'b0,1'b0,2'd0}; // idle
    vt[2]  = '{1'b0,1'b1,4'h0,4'h0,4'h0,4'h0, 1'b0,1'b0,4'hF,1'b0,1'b0,1'b0,2'd0}; // start
    vt[3]  = '{1'b0,1'b0,4'h0,4'h7,4'h0,4'h0, 1'b0,1'b0,4'h0,1'b0,1'b0,1'b0,2'd0}; // partial sleep
    vt[4]  = '{1'b0,1'b0,4'h0,4'hF,4'h0,4'h0, 1'b0,1'b0,4'h0,1'b1,1'b0,1'b0,2'd0}; // all sleep
    vt[5]  = '{1'b0,1'b0,4'h0,4'hF,4'h0,4'h0, 1'b0,1'b0,4'h0,1'b0,1'b0,1'b0,2'd0}; // cooldown
    vt[6]  = '{1'b0,1'b0,4'h0,4'h0,4'h0,4'h0, 1'b0,1'b0,4'h0,1'b0,1'b0,1'b0,2'd0};
    vt[7]  = '{1'b0,1'b1,4'h0,4'h0,4'h3,4'hC, 1'b0,1'b0,4'h0,1'b0,1'b1,1'b0,2'd1}; // sync round, start ignored
    vt[8]  = '{1'b0,1'b0,4'h0,4'h0,4'h3,4'hC, 1'b0,1'b0,4'h0,1'b0,1'b0,1'b0,2'd1}; // cooldown
    vt[9]  = '{1'b0,1'b0,4'h0,4'h0,4'h0,4'h0, 1'b0,1'b0,4'h0,1'b0,1'b0,1'b0,2'd1};
    vt[10] = '{1'b0,1'b0,4'h0,4'hC,4'h3,4'h0, 1'b0,1'b0,4'h0,1'b0,1'b0,1'b0,2'd1}; // mixed
    vt[11] = '{1'b0,1'b0,4'h0,4'h0,4'h0,4'hF, 1'b0,1'b0,4'h0,1'b0,1'b1,1'b1,2'd2}; // final round
    vt[12] = '{1'b0,1'b0,4'h0,4'h0,4'h0,4'h0, 1'b0,1'b0,4'h0,1'b0,1'b0,1'b0,2'd2}; // -> DRAIN
    vt[13] = '{1'b0,1'b0,4'h7,4'h0,4'h0,4'h0, 1'b0,1'b0,4'h0,1'b0,1'b0,1'b0,2'd2};
    vt[14] = '{1'b0,1'b0,4'hF,4'h0,4'h0,4'h0, 1'b1,1'b0,4'h0,1'b0,1'b0,1'b0,2'd2}; // DONE
    vt[15] = '{1'b0,1'b0,4'h0,4'h0,4'h0,4'h0, 1'b0,1'b1,4'h0,1'b0,1'b0,1'b0,2'd2}; // IDLE, holds
    vt[16] = '{1'b0,1'b0,4'h0,4'h0,4'h0,4'h0, 1'b0,1'b1,4'h0,1'b0,1'b0,1'b0,2'd2};
    vt[17] = '{1'b0,1'b1,4'h0,4'h0,4'h0,4'h0, 1'b0,1'b0,4'hF,1'b0,1'b0,1'b0,2'd0}; // restart clears
    vt[18] = '{1'b0,1'b0,4'h0,4'h0,4'h0,4'hF, 1'b0,1'b0,4'h0,1'b0,1'b1,1'b1,2'd1};
    vt[19] = '{1'b0,1'b0,4'h0,4'h0,4'h0,4'h0, 1'b0,1'b0,4'h0,1'b0,1'b0,1'b0,2'd1}; // DRAIN
    vt[20] = '{1'b1,1'b0,4'hF,4'h0,4'h0,4'h0, 1'b0,1'b1,4'h0,1'b0,1'b0,1'b0,2'd0}; // reset in DRAIN
    vt[21] = '{1'b0,1'b0,4'h0,4'h0,4'h0,4'h0, 1'b0,1'b1,4'h0,1'b0,1'b0,1'b0,2'd0};
    vt[22] = '{1'b0,1'b1,4'h0,4'h0,4'h0,4'h0, 1'b0,1'b0,4'hF,1'b0,1'b0,1'b0,2'd0};
    vt[23] = '{1'b0,1'b0,4'h0,4'hF,4'hF,4'h0, 1'b0,1'b0,4'h0,1'b0,1'b1,1'b0,2'd1}; // S&Y: Y wins
    vt[24] = '{1'b0,1'b0,4'h0,4'h0,4'hF,4'h0, 1'b0,1'b0,4'h0,1'b0,1'b0,1'b0,2'd1};
    vt[25] = '{1'b0,1'b0,4'h0,4'h0,4'hF,4'h0, 1'b0,1'b0,4'h0,1'b0,1'b1,1'b0,2'd2};
    vt[26] = '{1'b0,1'b0,4'h0,4'h0,4'hF,4'h0, 1'b0,1'b0,4'h0,1'b0,1'b0,1'b0,2'd2};
    vt[27] = '{1'b0,1'b0,4'h0,4'h0,4'hF,4'h0, 1'b0,1'b0,4'h0,1'b0,1'b1,1'b0,2'd3};
    vt[28] = '{1'b0,1'b0,4'h0,4'h0,4'hF,4'h0, 1'b0,1'b0,4'h0,1'b0,1'b0,1'b0,2'd3};
    vt[29] = '{1'b0,1'b0,4'h0,4'h0,4'hF,4'h0, 1'b0,1'b0,4'h0,1'b0,1'b1,1'b0,2'd3}; // saturated
    vt[30] = '{1'b0,1'b0,4'h0,4'h0,4'hF,4'h0, 1'b0,1'b0,4'h0,1'b0,1'b0,1'b0,2'd3};
    vt[31] = '{1'b0,1'b0,4'h0,4'h0,4'hF,4'h0, 1'b0,1'b0,4'h0,1'b0,1'b1,1'b0,2'd3};
    vt[32] = '{1'b0,1'b0,4'h0,4'h0,4'h0,4'hF, 1'b0,1'b0,4'h0,1'b0,1'b0,1'b0,2'd3}; // cooldown hides W
    vt[33] = '{1'b0,1'b0,4'h0,4'h0,4'h0,4'hF, 1'b0,1'b0,4'h0,1'b0,1'b1,1'b1,2'd3};
    vt[34] = '{1'b0,1'b0,4'hF,4'h0,4'h0,4'h0, 1'b0,1'b0,4'h0,1'b0,1'b0,1'b0,2'd3}; // -> DRAIN
    vt[35] = '{1'b0,1'b0,4'hF,4'h0,4'h0,4'h0, 1'b1,1'b0,4'h0,1'b0,1'b0,1'b0,2'd3}; // DONE
    vt[36] = '{1'b0,1'b0,4'h0,4'h0,4'h0,4'h0, 1'b0,1'b1,4'h0,1'b0,1'b0,1'b0,2'd3};

    drive(1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);

    for (int i = 0; i < NV; i++) begin
      drive(vt[i].rst, vt[i].start, vt[i].tidle, vt[i].slp, vt[i].sx, vt[i].sw);
      tick();
      chk($sformatf("v%0d.ap_done", i),       32'(bus.ap_done),       32'(vt[i].done));
      chk($sformatf("v%0d.ap_ready", i),      32'(bus.ap_ready),      32'(vt[i].done));
      chk($sformatf("v%0d.ap_idle", i),       32'(bus.ap_idle),       32'(vt[i].idle));
      chk($sformatf("v%0d.trigger_start", i), 32'(bus.trigger_start), 32'(vt[i].tstart));
      chk($sformatf("v%0d.all_sleep", i),     32'(bus.all_sleep),     32'(vt[i].asl));
      chk($sformatf("v%0d.all_sync", i),      32'(bus.all_sync),      32'(vt[i].asy));
      chk($sformatf("v%0d.all_sync_wait", i), 32'(bus.all_sync_wait), 32'(vt[i].asw));
      chk($sformatf("v%0d.sync_rounds", i),   32'(bus.sync_rounds),   32'(exp_rounds(vt[i].rnd)));
    end

    // Hand sequence: single-cycle start pulse, final barrier, bounded drain wait.
    drive(1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0);
    tick();
    chk("seq.tstart_on", 32'(bus.trigger_start), 32'hF);
    drive(1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'hF);
    tick();
    chk("seq.tstart_off", 32'(bus.trigger_start), 32'h0);
    chk("seq.asw", 32'(bus.all_sync_wait), 32'h1);
    chk("seq.rounds", 32'(bus.sync_rounds), 32'(exp_rounds(2'd1)));
    drive(1'b0, 1'b0, 4'hF, 4'h0, 4'h0, 4'h0);
    k = 0;
    while (bus.ap_done !== 1'b1 && k < 8) begin
      tick();
      k++;
    end
    chk("seq.drain_latency", 32'(k), 32'd2);
    chk("seq.ready", 32'(bus.ap_ready), 32'h1);
    chk("seq.done_idle", 32'(bus.ap_idle), 32'h0);
    tick();
    chk("seq.done_once", 32'(bus.ap_done), 32'h0);
    chk("seq.back_idle", 32'(bus.ap_idle), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
